fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 101 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch stage with a small circular queue between fetch and decode.
// A redirect flushes the queue and reloads the PC in the same cycle.
module fetch_queue #(
  parameter int unsigned   N        = 64,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [N-1:0]  RESET_PC = '0,
  parameter int unsigned   INC      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   PCSrc_F,
  input  logic [N-1:0]           PCBranch_F,
  output logic [N-1:0]           imem_addr_F,
  output logic                   imem_req_F,
  input  logic [31:0]            imem_rdata_F,
  output logic [31:0]            instr_D,
  output logic [N-1:0]           pc_D,
  output logic                   valid_D,
  input  logic                   ready_D,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam int unsigned   CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [N-1:0]  INC_N    = N'(INC);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [N-1:0]  pc_q, pc_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [N-1:0]  pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic full;
  logic push;
  logic pop;

  assign full        = (count_q == FULL_CNT);
  assign valid_D     = (count_q != '0);
  assign imem_req_F  = !PCSrc_F && !full;
  assign push        = imem_req_F;
  assign pop         = valid_D && ready_D && !PCSrc_F;

  assign imem_addr_F = pc_q;
  assign count       = count_q;
  assign instr_D     = instr_mem[head_q];
  assign pc_D        = pc_mem[head_q];

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (PCSrc_F) begin
      // Flush by collapsing head onto tail; stale entries are simply overwritten later.
      pc_d    = PCBranch_F;
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push) begin
        pc_d   = pc_q + INC_N;
        tail_d = tail_q + PTR_ONE;
      end
      if (pop) begin
        head_d = head_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; it is only observed while valid_D is high.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]    <= pc_q;
      instr_mem[tail_q] <= imem_rdata_F;
    end
  end

endmodule
